// File: rtl/jet_tag_pkg.sv
// Shared types and default sizes for the batchnorm jet-tagging datapath.
package jet_tag_pkg;

  localparam int unsigned JT_WIDTH       = 16;
  localparam int unsigned JT_NFRAC       = 10;
  localparam int unsigned JT_INPUT_SIZE  = 16;
  localparam int unsigned JT_OUTPUT_SIZE = 5;

  typedef logic signed [JT_WIDTH-1:0] feat_t;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    FILL_DROP = 2'd1,
    ISSUE     = 2'd2,
    WAIT      = 2'd3
  } loader_state_e;

endpackage

// File: rtl/jet_feature_loader.sv
// Streams signed features into a frame buffer and hands complete frames to the
// network core as a stable parallel array, holding off until the core is done.
module jet_feature_loader
  import jet_tag_pkg::*;
#(
  parameter int unsigned WIDTH      = JT_WIDTH,
  parameter int unsigned NFRAC      = JT_NFRAC,
  parameter int unsigned INPUT_SIZE = JT_INPUT_SIZE,
  parameter int unsigned CNT_W      = $clog2(INPUT_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    input_ready,
  output logic signed [WIDTH-1:0] input_data [INPUT_SIZE],
  input  logic                    nn_done,
  output logic                    busy,
  output logic                    frame_err,
  output logic [15:0]             frame_count
);

  localparam int unsigned LAST_IDX = INPUT_SIZE - 1;

  // Fixed-point format is only meaningful if the integer part exists.
  if (NFRAC >= WIDTH) begin : g_bad_nfrac
    $error("NFRAC must be smaller than WIDTH");
  end
  if (INPUT_SIZE < 2) begin : g_bad_size
    $error("INPUT_SIZE must be at least 2");
  end

  loader_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [WIDTH-1:0] asm_buf [LAST_IDX];
  logic                   beat;
  logic                   buf_we;
  logic                   capture;
  logic                   err_d;

  // Reset overrides acceptance so no beat is consumed while the loader clears.
  assign s_ready = !reset && ((state_q == FILL) || (state_q == FILL_DROP));
  assign beat    = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_we  = 1'b0;
    capture = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (beat) begin
          if (cnt_q == CNT_W'(LAST_IDX)) begin
            cnt_d = '0;
            if (s_last) begin
              capture = 1'b1;
              state_d = ISSUE;
            end else begin
              err_d   = 1'b1;
              state_d = FILL_DROP;
            end
          end else begin
            buf_we = 1'b1;
            if (s_last) begin
              err_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      FILL_DROP: begin
        if (beat && s_last) state_d = FILL;
      end
      // A completion already seen during the strobe cycle skips WAIT.
      ISSUE:   state_d = nn_done ? FILL : WAIT;
      WAIT:    if (nn_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      input_ready <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      for (int unsigned i = 0; i < LAST_IDX; i++) asm_buf[i] <= '0;
      for (int unsigned i = 0; i < INPUT_SIZE; i++) input_data[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      input_ready <= capture;
      frame_err   <= err_d;
      busy        <= (state_d == ISSUE) || (state_d == WAIT);
      if (buf_we) asm_buf[cnt_q] <= s_data;
      // Final beat bypasses the buffer so the frame lands in one edge.
      if (capture) begin
        for (int unsigned i = 0; i < LAST_IDX; i++) input_data[i] <= asm_buf[i];
        input_data[LAST_IDX] <= s_data;
        frame_count          <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_jet_feature_loader.sv
// Randomized bench for jet_feature_loader against a frame-level reference model.
module tb_jet_feature_loader;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               s_last;
  logic               input_ready;
  logic signed [15:0] input_data [16];
  logic               nn_done;
  logic               busy;
  logic               frame_err;
  logic [15:0]        frame_count;

  jet_feature_loader dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .input_ready (input_ready),
    .input_data  (input_data),
    .nn_done     (nn_done),
    .busy        (busy),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame state expressed as beat lists, not counters.
  bit          m_busy;
  bit          m_drop;
  logic [15:0] m_frame [$];
  logic [15:0] m_data [16];
  logic [15:0] m_count;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_frame.delete();
    m_count = 16'd0;
    for (int k = 0; k < 16; k++) m_data[k] = 16'd0;
  endtask

  task automatic model_beat(input logic [15:0] d, input logic last, output bit issue, output bit err);
    issue = 1'b0;
    err   = 1'b0;
    if (m_drop) begin
      if (last) m_drop = 1'b0;
    end else begin
      m_frame.push_back(d);
      if (m_frame.size() == 16) begin
        if (last) begin
          issue = 1'b1;
          for (int k = 0; k < 16; k++) m_data[k] = m_frame[k];
          m_count = m_count + 16'd1;
          m_busy  = 1'b1;
        end else begin
          err    = 1'b1;
          m_drop = 1'b1;
        end
        m_frame.delete();
      end else if (last) begin
        err = 1'b1;
        m_frame.delete();
      end
    end
  endtask

  function automatic bit data_matches();
    bit ok = 1'b1;
    for (int k = 0; k < 16; k++) if (input_data[k] !== m_data[k]) ok = 1'b0;
    return ok;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    s_last  = 1'($urandom);
    nn_done = 1'b0;
    #1;
    check_eq("s_ready_in_reset", 16'(s_ready), 16'd0);
    @(posedge clk); @(negedge clk);
    model_reset();
    check_eq("rst_input_ready", 16'(input_ready), 16'd0);
    check_eq("rst_frame_err", 16'(frame_err), 16'd0);
    check_eq("rst_busy", 16'(busy), 16'd0);
    check_eq("rst_frame_count", frame_count, 16'd0);
    check_eq("rst_data_zero", 16'(data_matches()), 16'd1);
    reset   = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("post_rst_s_ready", 16'(s_ready), 16'd1);
  endtask

  task automatic gap_cycle();
    s_valid = 1'b0;
    s_data  = 16'($urandom);
    s_last  = 1'($urandom);
    nn_done = 1'($urandom);
    @(posedge clk); @(negedge clk);
    nn_done = 1'b0;
    check_eq("gap_input_ready", 16'(input_ready), 16'd0);
    check_eq("gap_frame_err", 16'(frame_err), 16'd0);
    check_eq("gap_s_ready", 16'(s_ready), 16'(!m_busy));
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    bit ei, ee;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    model_beat(d, last, ei, ee);
    check_eq("input_ready", 16'(input_ready), 16'(ei));
    check_eq("frame_err", 16'(frame_err), 16'(ee));
    if (ei) begin
      for (int k = 0; k < 16; k++) check_eq($sformatf("data[%0d]", k), input_data[k], m_data[k]);
      check_eq("issue_busy", 16'(busy), 16'd1);
      check_eq("issue_s_ready", 16'(s_ready), 16'd0);
    end
  endtask

  // mode 0: 0x0400*k, mode 1: -1.0, mode 2: random. alt inserts one idle cycle per beat.
  task automatic send_seq(input int n, input int mode, input int gapmax, input bit alt, input bit with_last);
    logic [15:0] d;
    for (int k = 0; k < n; k++) begin
      int gaps = alt ? 1 : int'($urandom_range(gapmax, 0));
      if (k == 0) gaps = 0;
      repeat (gaps) gap_cycle();
      case (mode)
        0:       d = 16'(16'h0400 * k);
        1:       d = 16'hFC00;
        default: d = 16'($urandom);
      endcase
      send_beat(d, with_last && (k == n - 1));
    end
  endtask

  task automatic finish_core(input int wait_cycles, input bit junk);
    repeat (wait_cycles) begin
      s_valid = junk;
      s_data  = 16'h7FFF;
      s_last  = 1'($urandom);
      @(posedge clk); @(negedge clk);
      check_eq("wait_s_ready", 16'(s_ready), 16'd0);
      check_eq("wait_busy", 16'(busy), 16'd1);
      check_eq("wait_input_ready", 16'(input_ready), 16'd0);
      check_eq("wait_data_stable", 16'(data_matches()), 16'd1);
      check_eq("wait_frame_count", frame_count, m_count);
    end
    s_valid = 1'b0;
    nn_done = 1'b1;
    @(posedge clk); @(negedge clk);
    nn_done = 1'b0;
    m_busy  = 1'b0;
    check_eq("done_s_ready", 16'(s_ready), 16'd1);
    check_eq("done_busy", 16'(busy), 16'd0);
    check_eq("done_frame_count", frame_count, m_count);
    check_eq("done_data_stable", 16'(data_matches()), 16'd1);
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    nn_done = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Ramp frame, then core held off with junk traffic.
    send_seq(16, 0, 0, 1'b0, 1'b1);
    finish_core(20, 1'b1);

    // Short frame followed by a good one.
    send_seq(5, 2, 1, 1'b0, 1'b1);
    send_seq(16, 2, 1, 1'b0, 1'b1);
    finish_core(3, 1'b1);

    // Long frame is dropped through its s_last.
    send_seq(20, 2, 1, 1'b0, 1'b1);
    send_seq(16, 2, 0, 1'b0, 1'b1);
    finish_core(2, 1'b0);

    // Toggling valid with negative data; completion during the strobe cycle.
    send_seq(16, 1, 0, 1'b1, 1'b1);
    finish_core(0, 1'b0);

    // Reset in the middle of a frame, then reset while waiting on the core.
    send_seq(8, 2, 0, 1'b0, 1'b0);
    do_reset();
    send_seq(16, 2, 0, 1'b0, 1'b1);
    finish_core(3, 1'b1);
    send_seq(16, 2, 0, 1'b0, 1'b1);
    do_reset();
    send_seq(16, 0, 1, 1'b0, 1'b1);
    finish_core(1, 1'b1);

    // Random mix of good, short and long frames.
    for (int f = 0; f < 40; f++) begin
      int sel = int'($urandom_range(9, 0));
      int len = (sel < 6) ? 16 : (sel < 8) ? int'($urandom_range(15, 1)) : int'($urandom_range(24, 17));
      send_seq(len, 2, 2, 1'b0, 1'b1);
      if (m_busy) finish_core(int'($urandom_range(5, 0)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jet_feature_loader.md
Name: jet_feature_loader

Overview:
- Upstream feeder for the batchnorm jet-tagging network core.
- Accepts one signed Q(WIDTH-NFRAC).NFRAC feature per beat over a valid/ready stream, framed by s_last.
- Assembles INPUT_SIZE features and presents them as a stable parallel array, with a one-cycle input_ready strobe to the network core.
- Blocks new frames until the core reports completion on its output_ready, which connects to nn_done here.

Parameters:
WIDTH, 16, feature word width (signed fixed point)
NFRAC, 10, fractional bits; carried for consistency only, no arithmetic is done on it
INPUT_SIZE, 16, features per frame
CNT_W, $clog2(INPUT_SIZE), width of the beat index counter

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
s_valid  in  1  upstream beat valid
s_ready  out  1  loader can accept a beat
s_data  in  WIDTH signed  feature value
s_last  in  1  marks the final beat of a frame
input_ready  out  1  one-cycle strobe: input_data holds a new frame
input_data  out  WIDTH signed x [0:INPUT_SIZE-1]  assembled frame, registered
nn_done  in  1  completion pulse from the network core (its output_ready)
busy  out  1  high in ISSUE and WAIT
frame_err  out  1  one-cycle pulse when a malformed frame is dropped
frame_count  out  16  frames issued, wraps 0xFFFF -> 0

Behaviour:
- Reset (synchronous, active-high): state=FILL, cnt=0, all assembly and output registers = 0, frame_count=0. input_ready=0, frame_err=0, busy=0.
- s_ready is forced to 0 in any cycle where reset=1.
- Reset mid-frame discards the partial frame. Reset during WAIT drops the pending nn_done expectation.
- A beat is accepted when s_valid && s_ready.
- State FILL: s_ready=1.
  - On each accepted beat: asm_buf[cnt] <= s_data.
  - Beat with cnt < INPUT_SIZE-1 and s_last=0: cnt++.
  - Beat with cnt < INPUT_SIZE-1 and s_last=1 (short frame): frame_err pulses next cycle, cnt <= 0, stay in FILL, input_data unchanged.
  - Beat with cnt == INPUT_SIZE-1 and s_last=0 (long frame): frame_err pulse, cnt <= 0, discard the frame. Following beats up to and including the next s_last are also discarded, via a drop flag (state FILL_DROP, s_ready=1, no writes). Exit to FILL after the s_last beat.
  - Beat with cnt == INPUT_SIZE-1 and s_last=1: input_data[0..INPUT_SIZE-2] <= asm_buf, input_data[INPUT_SIZE-1] <= s_data, cnt <= 0, go to ISSUE.
- State ISSUE (exactly 1 cycle): input_ready=1, s_ready=0, busy=1, frame_count++. Go to WAIT.
- State WAIT: s_ready=0, busy=1.
  - On nn_done=1: go to FILL, so s_ready=1 in the next cycle.
  - nn_done seen in the ISSUE cycle is also accepted; the next cycle goes to FILL.
  - nn_done in FILL/FILL_DROP is ignored.
- Latency: last beat accepted at edge T; input_ready=1 and new input_data visible during cycle T+1.
- Latency: nn_done=1 sampled at edge T; s_ready=1 during cycle T+1.
- input_data changes only on the frame-completion edge. It is stable from input_ready through the whole network computation.
- s_data, s_last and s_valid are ignored when no beat is accepted.
- No backpressure toward the core: input_ready is a strobe, not a handshake.

Decomposition:
- Shared package jet_tag_pkg holds:
  - default WIDTH, NFRAC, INPUT_SIZE, OUTPUT_SIZE
  - typedef feat_t = logic signed [WIDTH-1:0]
  - loader state enum {FILL, FILL_DROP, ISSUE, WAIT}
- Single module, no sub-module needed. The 16-bit frame_count may be an inline counter.

Test Plan:
- Reset then 16 beats, s_data = 0x0400*k for k=0..15 (wrapping at 16 bits), s_last on beat 15 -> input_ready=1 for exactly one cycle, one cycle after beat 15. input_data[k] matches, frame_count=1, busy=1, s_ready=0.
- While in WAIT, drive s_valid=1 for 20 cycles with 0x7FFF, then nn_done pulse -> no beat accepted, input_data unchanged. s_ready=1 on the cycle after nn_done.
- Short frame: 5 beats with s_last on beat 4 -> frame_err pulse, no input_ready, cnt restarts. A following valid 16-beat frame issues normally with correct data.
- Long frame: 20 beats with s_last only on beat 19 -> frame_err at beat 15, beats 16..19 dropped, no input_ready. Next valid frame is accepted.
- s_valid toggling 1/0 every cycle over a frame with negative values 0xFC00 (-1.0) -> all 16 captured correctly, input_ready after the 16th accepted beat.
- Reset asserted at beat 8, then reset asserted during WAIT -> outputs return to 0 and state to FILL. frame_count=0. A subsequent full frame issues normally. Also preload frame_count to 0xFFFF via 65535 frames or force -> wraps to 0.
